// File: rtl/card_pkg.sv
// card_pkg: shared card types and default geometry for the card hand renderer.
package card_pkg;
    localparam int CARD_CODE_W = 6;
    localparam logic [CARD_CODE_W-1:0] CARD_BACK = 6'd52;

    localparam int DEF_NUM_CARDS = 9;
    localparam int DEF_XPOS      = 150;
    localparam int DEF_YPOS      = 80;
    localparam int DEF_X_STEP    = 30;
    localparam int DEF_CARD_W    = 24;
    localparam int DEF_CARD_H    = 36;
    localparam logic [11:0] DEF_KEY_RGB = 12'h0F0;

    typedef struct packed {
        logic [CARD_CODE_W-1:0] code;
        logic                   down;
    } card_slot_t;
endpackage

// File: rtl/vga_if.sv
// vga_if: VGA pixel stream bundle (timing counters, syncs, blanks, rgb).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/card_hand_table.sv
// card_hand_table: pending card table (push/flip/clear) and frame-synchronous active copy.
//   clk, rst (async active-low), push_valid/push_code/push_down/push_ready handshake,
//   flip_valid/flip_idx, clear, vblnk (commit trigger), count (pending),
//   active_count/active (table used for drawing).
module card_hand_table
    import card_pkg::*;
#(
    parameter int NUM_CARDS = DEF_NUM_CARDS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_valid,
    input  logic [CARD_CODE_W-1:0]            push_code,
    input  logic                              push_down,
    output logic                              push_ready,
    input  logic                              flip_valid,
    input  logic [3:0]                        flip_idx,
    input  logic                              clear,
    input  logic                              vblnk,
    output logic [4:0]                        count,
    output logic [4:0]                        active_count,
    output card_slot_t [NUM_CARDS-1:0]        active
);
    card_slot_t [NUM_CARDS-1:0] pend, pend_nxt;
    logic [4:0] count_nxt;
    logic       ready_en, vblnk_q, accept, commit;

    // ready_en holds push_ready low for the first cycle after reset release
    assign push_ready = ready_en && !clear && count < 5'(NUM_CARDS);
    assign accept     = push_valid && push_ready;
    assign commit     = vblnk && !vblnk_q;

    // the flip is checked against the post-push count so a same-cycle push+flip lands face-up
    always_comb begin
        pend_nxt  = pend;
        count_nxt = clear ? 5'd0 : count + 5'(accept);
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (accept && count == 5'(i))
                pend_nxt[i] = '{code: push_code, down: push_down};
            if (flip_valid && !clear && {1'b0, flip_idx} < count_nxt && flip_idx == 4'(i))
                pend_nxt[i].down = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en     <= 1'b0;
            vblnk_q      <= 1'b0;
            count        <= '0;
            pend         <= '0;
            active       <= '0;
            active_count <= '0;
        end else begin
            ready_en <= 1'b1;
            vblnk_q  <= vblnk;
            count    <= count_nxt;
            pend     <= pend_nxt;
            if (commit) begin
                active       <= pend;
                active_count <= count;
            end
        end
    end
endmodule

// File: rtl/card_hand_renderer.sv
// card_hand_renderer: overlays a hand of overlapping card sprites onto the VGA stream.
//   clk, rst (async active-low), vga_in/vga_out (2-cycle delayed stream),
//   push_valid/push_code/push_down/push_ready, flip_valid/flip_idx, clear, count,
//   rom_addr/rom_data (shared sprite ROM, 1-cycle read latency).
//   Optional macro CARD_HAND_SHADOW_EN adds a 2-pixel drop shadow right of the top card.
module card_hand_renderer
    import card_pkg::*;
#(
    parameter int          NUM_CARDS = DEF_NUM_CARDS,
    parameter int          XPOS      = DEF_XPOS,
    parameter int          YPOS      = DEF_YPOS,
    parameter int          X_STEP    = DEF_X_STEP,
    parameter int          CARD_W    = DEF_CARD_W,
    parameter int          CARD_H    = DEF_CARD_H,
    parameter logic [11:0] KEY_RGB   = DEF_KEY_RGB
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_if.in                      vga_in,
    vga_if.out                     vga_out,
    input  logic                   push_valid,
    input  logic [CARD_CODE_W-1:0] push_code,
    input  logic                   push_down,
    output logic                   push_ready,
    input  logic                   flip_valid,
    input  logic [3:0]             flip_idx,
    input  logic                   clear,
    output logic [3:0]             count,
    output logic [16:0]            rom_addr,
    input  logic [11:0]            rom_data
);
    card_slot_t [NUM_CARDS-1:0] active;
    logic [4:0]  count_full, active_count;
    logic        hit_d, hit_q;
    logic [3:0]  win;
    logic [CARD_CODE_W-1:0] code_s;
    logic [16:0] addr_d;
    int          hx, vy, addr_i;
    logic [10:0] hcount_d1, vcount_d1;
    logic        hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
    logic [11:0] rgb_d1, rgb_nxt;
    logic        blank_d1;

    card_hand_table #(.NUM_CARDS(NUM_CARDS)) u_table (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_code    (push_code),
        .push_down    (push_down),
        .push_ready   (push_ready),
        .flip_valid   (flip_valid),
        .flip_idx     (flip_idx),
        .clear        (clear),
        .vblnk        (vga_in.vblnk),
        .count        (count_full),
        .active_count (active_count),
        .active       (active)
    );

    assign count = 4'(count_full);

    // S1: later slots are drawn on top, so the last hitting index wins
    always_comb begin
        hx    = int'(vga_in.hcount);
        vy    = int'(vga_in.vcount);
        hit_d = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (i < int'(active_count) && hx >= XPOS + i*X_STEP && hx < XPOS + i*X_STEP + CARD_W &&
                vy >= YPOS && vy < YPOS + CARD_H) begin
                hit_d = 1'b1;
                win   = 4'(i);
            end
        end
        code_s = active[win].down ? CARD_BACK : active[win].code;
        addr_i = int'(code_s)*CARD_W*CARD_H + (vy - YPOS)*CARD_W + (hx - XPOS - int'(win)*X_STEP);
        addr_d = hit_d ? 17'(addr_i) : '0;
    end

`ifdef CARD_HAND_SHADOW_EN
    logic shadow_d, shadow_q;
    int   xt;

    always_comb begin
        xt       = XPOS + (int'(active_count) - 1)*X_STEP;
        shadow_d = active_count != '0 && !hit_d && hx >= xt + CARD_W && hx < xt + CARD_W + 2 &&
                   vy >= YPOS + 2 && vy < YPOS + CARD_H + 2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shadow_q <= 1'b0;
        else      shadow_q <= shadow_d;
    end
`endif

    assign blank_d1 = hblnk_d1 || vblnk_d1;

    always_comb begin
        rgb_nxt = (hit_q && rom_data != KEY_RGB && !blank_d1) ? rom_data : rgb_d1;
`ifdef CARD_HAND_SHADOW_EN
        if (shadow_q && !blank_d1)
            rgb_nxt = {1'b0, rgb_d1[11:9], 1'b0, rgb_d1[7:5], 1'b0, rgb_d1[3:1]};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q          <= 1'b0;
            rom_addr       <= '0;
            hcount_d1      <= '0;
            vcount_d1      <= '0;
            hsync_d1       <= 1'b0;
            vsync_d1       <= 1'b0;
            hblnk_d1       <= 1'b0;
            vblnk_d1       <= 1'b0;
            rgb_d1         <= '0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            hit_q          <= hit_d;
            rom_addr       <= addr_d;
            hcount_d1      <= vga_in.hcount;
            vcount_d1      <= vga_in.vcount;
            hsync_d1       <= vga_in.hsync;
            vsync_d1       <= vga_in.vsync;
            hblnk_d1       <= vga_in.hblnk;
            vblnk_d1       <= vga_in.vblnk;
            rgb_d1         <= vga_in.rgb;
            vga_out.hcount <= hcount_d1;
            vga_out.vcount <= vcount_d1;
            vga_out.hsync  <= hsync_d1;
            vga_out.vsync  <= vsync_d1;
            vga_out.hblnk  <= hblnk_d1;
            vga_out.vblnk  <= vblnk_d1;
            vga_out.rgb    <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_card_hand_renderer.sv
// tb_card_hand_renderer: directed checks of the card hand renderer (default and X_STEP=10 instances).
module tb_card_hand_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_valid, push_down, flip_valid, clear;
    logic [5:0]  push_code;
    logic [3:0]  flip_idx;
    logic [11:0] rom_data;
    logic        push_ready1, push_ready2;
    logic [3:0]  count1, count2;
    logic [16:0] rom_addr1, rom_addr2;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    vga_if vin ();
    vga_if vo1 ();
    vga_if vo2 ();

    card_hand_renderer dut1 (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vo1),
        .push_valid(push_valid), .push_code(push_code), .push_down(push_down), .push_ready(push_ready1),
        .flip_valid(flip_valid), .flip_idx(flip_idx), .clear(clear), .count(count1),
        .rom_addr(rom_addr1), .rom_data(rom_data)
    );

    card_hand_renderer #(.X_STEP(10)) dut2 (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vo2),
        .push_valid(push_valid), .push_code(push_code), .push_down(push_down), .push_ready(push_ready2),
        .flip_valid(flip_valid), .flip_idx(flip_idx), .clear(clear), .count(count2),
        .rom_addr(rom_addr2), .rom_data(rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] code, input logic down);
        push_valid = 1'b1;
        push_code  = code;
        push_down  = down;
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic new_frame();
        vin.vblnk = 1'b1;
        @(posedge clk); #1;
        vin.vblnk = 1'b0;
        @(posedge clk); #1;
    endtask

    // one pixel: check S1 address, then the stage-2 output after the input has moved on
    task automatic pix(input string tag, input int h, input int v, input logic [11:0] rgb,
                       input logic [11:0] rd, input logic blnk, input int a1, input int a2,
                       input logic [11:0] r1, input logic [11:0] r2);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.rgb    = rgb;
        vin.hblnk  = blnk;
        vin.hsync  = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_addr1"}, 32'(rom_addr1), a1);
        chk({tag, "_addr2"}, 32'(rom_addr2), a2);
        vin.hcount = '0;
        vin.vcount = '0;
        vin.rgb    = '0;
        vin.hblnk  = 1'b0;
        vin.hsync  = 1'b0;
        rom_data   = rd;
        @(posedge clk); #1;
        chk({tag, "_rgb1"}, 32'(vo1.rgb), 32'(r1));
        chk({tag, "_rgb2"}, 32'(vo2.rgb), 32'(r2));
        chk({tag, "_hcnt"}, 32'(vo1.hcount), h);
        chk({tag, "_vcnt"}, 32'(vo1.vcount), v);
        chk({tag, "_hsync"}, 32'(vo1.hsync), 1);
        chk({tag, "_hblnk"}, 32'(vo1.hblnk), 32'(blnk));
    endtask

    initial begin
        push_valid = 0; push_code = 0; push_down = 0;
        flip_valid = 0; flip_idx = 0; clear = 0; rom_data = 0;
        vin.hcount = 11'd5; vin.vcount = 11'd7; vin.hsync = 1; vin.vsync = 1;
        vin.hblnk = 0; vin.vblnk = 0; vin.rgb = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count1), 0);
        chk("rst_addr", 32'(rom_addr1), 0);
        chk("rst_rgb", 32'(vo1.rgb), 0);
        chk("rst_hsync", 32'(vo1.hsync), 0);
        chk("rst_hcount", 32'(vo1.hcount), 0);
        vin.hcount = 0; vin.vcount = 0; vin.hsync = 0; vin.vsync = 0; vin.rgb = 0;
        rst = 1'b1;
        #1;
        chk("ready_first", 32'(push_ready1), 0);
        @(posedge clk); #1;
        chk("ready_after", 32'(push_ready1), 1);

        push(6'd0, 0); push(6'd13, 0); push(6'd51, 0);
        chk("count3", 32'(count1), 3);
        chk("count3_b", 32'(count2), 3);
        pix("prevblnk", 150, 80, 12'hABC, 12'h123, 0, 0, 0, 12'hABC, 12'hABC);
        new_frame();
        pix("c0", 150, 80, 12'hABC, 12'h123, 0, 0, 0, 12'h123, 12'h123);
        pix("c2", 210, 80, 12'h0AA, 12'h456, 0, 44064, 0, 12'h456, 12'h0AA);
        pix("ovl", 165, 90, 12'h111, 12'h222, 0, 255, 11477, 12'h222, 12'h222);
        pix("key", 150, 80, 12'h5A5, 12'h0F0, 0, 0, 0, 12'h5A5, 12'h5A5);
        pix("blnk", 160, 85, 12'h5A5, 12'h777, 1, 130, 11352, 12'h5A5, 12'h5A5);

        push(6'd7, 0);
        chk("count4", 32'(count1), 4);
        clear = 1; push_valid = 1; push_code = 6'd9;
        #1;
        chk("clr_ready", 32'(push_ready1), 0);
        @(posedge clk); #1;
        clear = 0; push_valid = 0;
        chk("clr_count", 32'(count1), 0);
        new_frame();
        pix("cleared", 150, 80, 12'h321, 12'h123, 0, 0, 0, 12'h321, 12'h321);

        push(6'd5, 1);
        new_frame();
        pix("down", 150, 80, 12'h000, 12'h999, 0, 44928, 44928, 12'h999, 12'h999);
        flip_valid = 1; flip_idx = 0;
        @(posedge clk); #1;
        flip_valid = 0;
        pix("down_same", 150, 80, 12'h000, 12'h999, 0, 44928, 44928, 12'h999, 12'h999);
        new_frame();
        pix("flipped", 150, 80, 12'h000, 12'h999, 0, 4320, 4320, 12'h999, 12'h999);

        for (int c = 10; c < 18; c++) push(6'(c), 0);
        chk("count9", 32'(count1), 9);
        chk("full_ready", 32'(push_ready1), 0);
        push(6'd40, 0);
        chk("count9_hold", 32'(count1), 9);
        new_frame();
        pix("slot8", 390, 80, 12'h000, 12'h888, 0, 14688, 0, 12'h888, 12'h000);

        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        push_valid = 1; push_code = 6'd20; push_down = 1; flip_valid = 1; flip_idx = 0;
        @(posedge clk); #1;
        push_valid = 0; flip_valid = 0; push_down = 0;
        chk("pf_count", 32'(count1), 1);
        new_frame();
        pix("pushflip", 150, 80, 12'h000, 12'hABC, 0, 17280, 17280, 12'hABC, 12'hABC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
